// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches opcode+operand bytes over a
// ready handshake with a timeout, and resolves jumps during execute/increment.
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clock,
  input  logic                  input_clear,
  input  logic                  input_clock_enable,
  input  logic                  fetch,
  input  logic                  execute,
  input  logic                  increment,
  input  logic                  jump,
  input  logic                  jumpz,
  input  logic                  jumpnz,
  input  logic                  jumpc,
  input  logic                  jumpnc,
  input  logic                  flag_zero,
  input  logic                  flag_carry,
  input  logic [7:0]            mem_data,
  input  logic                  mem_ready,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            output_ir,
  output logic [7:0]            output_operand,
  output logic [ADDR_WIDTH-1:0] output_pc,
  output logic                  output_stall,
  output logic                  output_fault
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_OP  = 2'd1,
    REQ_ARG = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   wait_cnt_r;
  logic            jump_taken_r;
  logic            take_s;
  logic            timeout_s;
  logic            byte_done_s;
  logic [7:0]      byte_val_s;
  logic [ADDR_WIDTH-1:0] pc_next_s;

  // Jump resolution, timeout detection and next-PC selection
  always_comb begin
    take_s = jump | (jumpz & flag_zero) | (jumpnz & ~flag_zero)
           | (jumpc & flag_carry) | (jumpnc & ~flag_carry);
    timeout_s   = (wait_cnt_r == WAIT_LAST);
    byte_done_s = mem_ready | timeout_s;
    // A timed-out byte reads as zero so the decoder sees a benign opcode
    byte_val_s  = mem_ready ? mem_data : 8'h00;
    if (jump_taken_r) begin
      pc_next_s = ADDR_WIDTH'(output_operand);
    end else begin
      pc_next_s = output_pc + ADDR_WIDTH'(2);
    end
  end

  // Fetch FSM, PC and jump state; everything freezes when the clock enable is low
  always_ff @(posedge clock or posedge input_clear) begin
    if (input_clear) begin
      state_r        <= IDLE;
      wait_cnt_r     <= '0;
      jump_taken_r   <= 1'b0;
      mem_read       <= 1'b0;
      mem_addr       <= RESET_VECTOR;
      output_ir      <= 8'h00;
      output_operand <= 8'h00;
      output_pc      <= RESET_VECTOR;
      output_stall   <= 1'b0;
      output_fault   <= 1'b0;
    end else if (input_clock_enable) begin
      case (state_r)
        IDLE: begin
          if (fetch) begin
            state_r      <= REQ_OP;
            mem_read     <= 1'b1;
            mem_addr     <= output_pc;
            output_stall <= 1'b1;
            wait_cnt_r   <= '0;
          end else if (execute) begin
            jump_taken_r <= take_s;
          end else if (increment) begin
            output_pc    <= pc_next_s;
            jump_taken_r <= 1'b0;
          end
        end
        REQ_OP: begin
          if (byte_done_s) begin
            output_ir    <= byte_val_s;
            output_fault <= output_fault | ~mem_ready;
            state_r      <= REQ_ARG;
            mem_addr     <= output_pc + ADDR_WIDTH'(1);
            wait_cnt_r   <= '0;
          end else begin
            wait_cnt_r   <= wait_cnt_r + CW'(1);
          end
        end
        REQ_ARG: begin
          if (byte_done_s) begin
            output_operand <= byte_val_s;
            output_fault   <= output_fault | ~mem_ready;
            state_r        <= DONE;
            mem_read       <= 1'b0;
            output_stall   <= 1'b0;
            wait_cnt_r     <= '0;
          end else begin
            wait_cnt_r     <= wait_cnt_r + CW'(1);
          end
        end
        DONE: begin
          // One fetch per fetch-phase assertion: wait for fetch to drop
          if (!fetch) begin
            state_r <= IDLE;
            if (!execute && increment) begin
              output_pc    <= pc_next_s;
              jump_taken_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          mem_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: table of fetch/jump vectors
// plus hand sequences for clock-enable freeze, timeout and mid-fetch reset.
module tb_instruction_fetch_unit;

  logic       clock = 1'b0;
  logic       input_clear = 1'b1;
  logic       input_clock_enable = 1'b1;
  logic       fetch = 1'b0, execute = 1'b0, increment = 1'b0;
  logic       jump = 1'b0, jumpz = 1'b0, jumpnz = 1'b0, jumpc = 1'b0, jumpnc = 1'b0;
  logic       flag_zero = 1'b0, flag_carry = 1'b0;
  logic [7:0] mem_data = 8'h00;
  logic       mem_ready = 1'b0;
  logic       mem_read;
  logic [7:0] mem_addr;
  logic [7:0] output_ir, output_operand, output_pc;
  logic       output_stall, output_fault;

  instruction_fetch_unit dut (
    .clock(clock), .input_clear(input_clear), .input_clock_enable(input_clock_enable),
    .fetch(fetch), .execute(execute), .increment(increment),
    .jump(jump), .jumpz(jumpz), .jumpnz(jumpnz), .jumpc(jumpc), .jumpnc(jumpnc),
    .flag_zero(flag_zero), .flag_carry(flag_carry),
    .mem_data(mem_data), .mem_ready(mem_ready), .mem_read(mem_read), .mem_addr(mem_addr),
    .output_ir(output_ir), .output_operand(output_operand), .output_pc(output_pc),
    .output_stall(output_stall), .output_fault(output_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         dly;
    logic [4:0] strb;   // {jump, jumpz, jumpnz, jumpc, jumpnc}
    logic       fz;
    logic       fc;
    logic [7:0] exp_ir;
    logic [7:0] exp_op;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t        tbl[9];
  logic [7:0]  mem[256];
  logic [15:0] sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model_pc = 8'h00;
  int          delay = 0;
  bit          no_answer = 1'b0;
  int          lat = 0;

  // Memory model: answers after 'delay' wait cycles per byte, or never
  always @(negedge clock) begin
    if (!mem_read || no_answer) begin
      mem_ready = 1'b0;
      lat = 0;
    end else begin
      if (mem_ready) lat = 0;
      if (lat == delay) begin
        mem_ready = 1'b1;
        mem_data  = mem[mem_addr];
      end else begin
        mem_ready = 1'b0;
        lat = lat + 1;
      end
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic fetch_check(input int dly, input bit hang, input logic [7:0] eir,
                             input logic [7:0] eop, input int exp_stall);
    int per, idx, bad;
    logic [7:0]  ea;
    logic [15:0] got;
    delay = dly;
    no_answer = hang;
    per = hang ? 15 : dly + 1;
    idx = 0;
    bad = 0;
    sbq.push_back({eir, eop});
    fetch = 1'b1;
    step();
    while (output_stall && idx < 200) begin
      ea = model_pc + 8'(idx / per);
      if (!mem_read || mem_addr !== ea) bad++;
      idx++;
      step();
    end
    fetch = 1'b0;
    no_answer = 1'b0;
    checki("stall_cycles", idx, exp_stall);
    checki("addr_seq_bad", bad, 0);
    got = sbq.pop_front();
    check8("ir", output_ir, got[15:8]);
    check8("operand", output_operand, got[7:0]);
  endtask

  task automatic exec_inc(input logic [4:0] strb, input logic fz, input logic fc,
                          input logic [7:0] exp_pc);
    step();
    {jump, jumpz, jumpnz, jumpc, jumpnc} = strb;
    flag_zero = fz;
    flag_carry = fc;
    execute = 1'b1;
    step();
    execute = 1'b0;
    {jump, jumpz, jumpnz, jumpc, jumpnc} = 5'b00000;
    increment = 1'b1;
    step();
    increment = 1'b0;
    check8("pc_after_inc", output_pc, exp_pc);
    model_pc = exp_pc;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int bad, guard;
    logic [7:0]  held_addr;
    logic [15:0] got;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h40; mem[8'h01] = 8'h12; mem[8'h02] = 8'h41; mem[8'h03] = 8'h55;
    mem[8'h04] = 8'h80; mem[8'h05] = 8'h30; mem[8'h30] = 8'h80; mem[8'h31] = 8'h60;
    mem[8'h32] = 8'h90; mem[8'h33] = 8'hFF; mem[8'hFF] = 8'hA0; mem[8'h41] = 8'h00;
    mem[8'h42] = 8'hFE; mem[8'hFE] = 8'h11;

    tbl[0] = '{0, 5'b00000, 1'b0, 1'b0, 8'h40, 8'h12, 8'h02};
    tbl[1] = '{3, 5'b00000, 1'b0, 1'b0, 8'h41, 8'h55, 8'h04};
    tbl[2] = '{0, 5'b01000, 1'b1, 1'b0, 8'h80, 8'h30, 8'h30};
    tbl[3] = '{1, 5'b01000, 1'b0, 1'b0, 8'h80, 8'h60, 8'h32};
    tbl[4] = '{2, 5'b10000, 1'b0, 1'b0, 8'h90, 8'hFF, 8'hFF};
    tbl[5] = '{0, 5'b00000, 1'b0, 1'b0, 8'hA0, 8'h40, 8'h01};
    tbl[6] = '{0, 5'b00010, 1'b0, 1'b1, 8'h12, 8'h41, 8'h41};
    tbl[7] = '{0, 5'b00001, 1'b0, 1'b0, 8'h00, 8'hFE, 8'hFE};
    tbl[8] = '{0, 5'b00100, 1'b1, 1'b0, 8'h11, 8'hA0, 8'h00};

    // Reset state
    step();
    step();
    check8("rst_pc", output_pc, 8'h00);
    check8("rst_ir", output_ir, 8'h00);
    check8("rst_operand", output_operand, 8'h00);
    check8("rst_mem_read", 8'(mem_read), 8'h00);
    check8("rst_mem_addr", mem_addr, 8'h00);
    check8("rst_stall", 8'(output_stall), 8'h00);
    check8("rst_fault", 8'(output_fault), 8'h00);
    input_clear = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      fetch_check(tbl[i].dly, 1'b0, tbl[i].exp_ir, tbl[i].exp_op, 2 * (tbl[i].dly + 1));
      exec_inc(tbl[i].strb, tbl[i].fz, tbl[i].fc, tbl[i].exp_pc);
    end

    // Clock enable low mid-fetch: state and wait counter freeze
    no_answer = 1'b1;
    delay = 0;
    sbq.push_back({8'h40, 8'h12});
    fetch = 1'b1;
    repeat (10) step();
    held_addr = mem_addr;
    input_clock_enable = 1'b0;
    bad = 0;
    repeat (5) begin
      step();
      if (!output_stall || !mem_read || mem_addr !== held_addr || output_pc !== model_pc) bad++;
    end
    checki("freeze_hold_bad", bad, 0);
    input_clock_enable = 1'b1;
    repeat (3) step();
    no_answer = 1'b0;
    guard = 0;
    while (output_stall && guard < 50) begin
      step();
      guard++;
    end
    check8("freeze_stall_done", 8'(output_stall), 8'h00);
    fetch = 1'b0;
    got = sbq.pop_front();
    check8("freeze_ir", output_ir, got[15:8]);
    check8("freeze_operand", output_operand, got[7:0]);
    check8("freeze_no_fault", 8'(output_fault), 8'h00);
    exec_inc(5'b00000, 1'b0, 1'b0, 8'h02);

    // Memory never answers: both bytes time out, fault sticks
    fetch_check(0, 1'b1, 8'h00, 8'h00, 30);
    check8("timeout_fault", 8'(output_fault), 8'h01);
    exec_inc(5'b00000, 1'b0, 1'b0, 8'h04);
    check8("fault_sticky", 8'(output_fault), 8'h01);

    // Reset pulse mid-fetch
    no_answer = 1'b1;
    fetch = 1'b1;
    repeat (3) step();
    check8("midfetch_read", 8'(mem_read), 8'h01);
    @(negedge clock);
    input_clear = 1'b1;
    #1;
    check8("clear_mem_read", 8'(mem_read), 8'h00);
    check8("clear_pc", output_pc, 8'h00);
    check8("clear_stall", 8'(output_stall), 8'h00);
    check8("clear_fault", 8'(output_fault), 8'h00);
    fetch = 1'b0;
    step();
    input_clear = 1'b0;
    no_answer = 1'b0;
    step();
    model_pc = 8'h00;
    fetch_check(0, 1'b0, 8'h40, 8'h12, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Upstream stage of the instruction decoder. Owns the program counter, fetches a two-byte instruction (opcode byte, operand byte) from program memory over a ready handshake during the fetch phase, and presents the opcode byte to the decoder's instruction input. During execute it evaluates the decoder's jump strobes against ALU flags; during increment it advances or redirects the PC.

Parameters:
ADDR_WIDTH, 8, program counter and memory address width
RESET_VECTOR, 0, PC value after reset
MAX_WAIT, 15, cycles mem_read may stay unanswered before timeout fault

Ports:
clock  input  1  system clock, rising edge
input_clear  input  1  reset, asynchronous, active-high
input_clock_enable  input  1  global enable; low freezes all state
fetch  input  1  fetch phase from sequence generator
execute  input  1  execute phase from sequence generator
increment  input  1  increment phase from sequence generator
jump, jumpz, jumpnz, jumpc, jumpnc  input  1 each  decoder jump strobes, valid during execute
flag_zero  input  1  ALU zero flag
flag_carry  input  1  ALU carry flag
mem_data  input  8  program memory read data
mem_ready  input  1  memory read acknowledge
mem_read  output  1  memory read request
mem_addr  output  ADDR_WIDTH  memory read address
output_ir  output  8  opcode byte to decoder
output_operand  output  8  operand byte (jump target / immediate)
output_pc  output  ADDR_WIDTH  current program counter
output_stall  output  1  high while fetch in progress; gates sequencer clock enable externally
output_fault  output  1  sticky memory timeout flag

Behaviour:
- Reset (async, input_clear=1): PC=RESET_VECTOR, IR=0x00, operand=0x00, FSM=IDLE, mem_read=0, mem_addr=RESET_VECTOR, stall=0, fault=0, jump_taken=0, wait counter=0.
- input_clock_enable=0: no register, FSM or counter update; outputs hold.
- FSM states: IDLE, REQ_OP, REQ_ARG, DONE.
- IDLE: fetch=1 -> REQ_OP, stall=1 from next cycle.
- REQ_OP: mem_read=1, mem_addr=PC. mem_ready=1 same cycle -> IR<=mem_data, -> REQ_ARG.
- REQ_ARG: mem_read=1, mem_addr=PC+1 (mod 2^ADDR_WIDTH; 0xFF -> 0x00). mem_ready=1 -> operand<=mem_data, -> DONE.
- DONE: stall=0; stays until fetch=0, then -> IDLE (one fetch per fetch-phase assertion).
- mem_addr held stable while mem_read=1 and mem_ready=0; mem_ready while mem_read=0 ignored.
- Timeout: wait counter reset on entering each REQ state; reaching MAX_WAIT unanswered -> byte being fetched loads 0x00, fault<=1 (sticky until reset), advance as if ready.
- Execute (execute=1, FSM=IDLE): jump_taken<=jump | (jumpz&flag_zero) | (jumpnz&~flag_zero) | (jumpc&flag_carry) | (jumpnc&~flag_carry).
- Increment (increment=1): PC<=jump_taken ? operand[ADDR_WIDTH-1:0] : PC+2 (wraps); jump_taken<=0.
- Phase priority if several phase inputs high: fetch > execute > increment; lower ones ignored that cycle.
- execute/increment during an active fetch (REQ_*) ignored.
- Reset mid-fetch: mem_read drops immediately (async), partial bytes discarded.
- Latency: minimum fetch = 2 memory cycles; stall high from cycle after fetch detected through cycle operand captured.

Test Plan:
- Reset then fetch, mem at 0x00=0x40, 0x01=0x12, ready immediate -> mem_addr 0x00 then 0x01, IR=0x40, operand=0x12, stall high exactly 2 cycles; increment -> PC=0x02.
- Wait states: ready delayed 3 cycles per byte -> mem_addr stable, stall high 8 cycles, same IR/operand captured.
- Conditional jump: operand=0x30, jumpz=1 during execute, flag_zero=1 -> after increment PC=0x30; repeat with flag_zero=0 -> PC=old PC+2.
- Wrap: PC=0xFF -> operand fetched from 0x00; increment -> PC=0x01; PC=0xFE no jump -> PC=0x00.
- Timeout: mem_ready never asserted -> after MAX_WAIT=15 cycles IR=0x00, fault=1, FSM proceeds; fault stays until input_clear.
- input_clock_enable=0 mid-fetch for 5 cycles -> FSM, counter, PC frozen; resumes identically; input_clear pulse mid-fetch -> mem_read=0, PC=0x00 immediately.
